// File: rtl/uart_pkg.sv
// Shared types and constants for the extended UART receiver.
`timescale 1ns/1ps
package uart_pkg;

    // Receiver frame states, one per field of the serial frame.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_e;

    // Parity modes selected by the PARITY parameter.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // A stored entry is the payload plus parity and framing error flags.
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_ext_fifo.sv
// First-word fall-through FIFO holding received entries.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // Decide push/pop acceptance and compute next storage, pointers and flags.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        overflow = push && full_q && !do_pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Head entry shown straight from storage, blanked while nothing is held.
    always_comb begin
        rdata = empty_q ? '0 : mem_q[rd_ptr_q];
        full  = full_q;
        empty = empty_q;
        count = count_q;
    end

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with tick generator, error-flagging FIFO and overrun flag.
`timescale 1ns/1ps
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    input  logic                            rd_en,
    input  logic                            ovr_clr,
    output logic [DATA_BITS-1:0]            d_out,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overrun
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW   = $clog2(OVERSAMPLE);
    localparam int BW   = 4;
    localparam int HALF = OVERSAMPLE / 2;
    localparam int EW   = entry_width(DATA_BITS);

    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [OW-1:0]        os_cnt_q, os_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 push_q, push_d;
    logic                 ovr_q, ovr_d;
    logic                 os_end;
    logic                 sample;
    logic                 fifo_overflow;
    logic [EW-1:0]        fifo_rdata;

    // Two-stage synchroniser for the asynchronous line, idling high.
    always_comb begin
        sync_d = {sync_q[0], rx};
        rx_s   = sync_q[1];
    end

    // Free-running oversample tick divider.
    always_comb begin
        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // Frame FSM: locate mid-bit sample points and assemble the entry.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        push_d    = 1'b0;
        os_end    = (state_q == ST_START) ? (os_cnt_q == OW'(HALF - 1))
                                          : (os_cnt_q == OW'(OVERSAMPLE - 1));
        sample    = tick && os_end;
        if (state_q != ST_IDLE && tick) begin
            os_cnt_d = os_end ? '0 : os_cnt_q + OW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                os_cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (sample) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        pe_d      = 1'b0;
                        fe_d      = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PAR: begin
                if (sample) begin
                    pe_d    = (PARITY == PARITY_ODD) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    if (!rx_s) begin
                        fe_d = 1'b1;
                    end
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        push_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky overrun: a dropped frame takes priority over a clear.
    always_comb begin
        if (fifo_overflow) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // All receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            push_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            push_q     <= push_d;
            ovr_q      <= ovr_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .wdata    ({fe_q, pe_q, shift_q}),
        .pop      (rd_en),
        .rdata    (fifo_rdata),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (fifo_overflow)
    );

    // Split the head entry into payload and error flags.
    always_comb begin
        d_out      = fifo_rdata[DATA_BITS-1:0];
        parity_err = (PARITY != PARITY_NONE) && fifo_rdata[DATA_BITS];
        frame_err  = fifo_rdata[DATA_BITS+1];
        overrun    = ovr_q;
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext across several parameter sets.
`timescale 1ns/1ps
module tb_uart_rx_ext;
    import uart_pkg::*;

    // 100 MHz clock, 3.125 Mbaud x16 gives a 2-cycle tick and 32-cycle bit.
    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int BIT_NS   = 320;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line [0:4];
    logic rd_v    [0:4];
    logic clr_v   [0:4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: 8N1 depth 16, p: even parity, s: two stop bits, o: depth 4, w: 5 bits odd parity
    logic [7:0] a_dout, p_dout, s_dout, o_dout;
    logic [4:0] w_dout;
    logic a_pe, a_fe, a_empty, a_full, a_ovr;
    logic p_pe, p_fe, p_empty, p_full, p_ovr;
    logic s_pe, s_fe, s_empty, s_full, s_ovr;
    logic o_pe, o_fe, o_empty, o_full, o_ovr;
    logic w_pe, w_fe, w_empty, w_full, w_ovr;
    logic [4:0] a_count, p_count, s_count, w_count;
    logic [2:0] o_count;

    uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_line[0]), .rd_en(rd_v[0]), .ovr_clr(clr_v[0]),
        .d_out(a_dout), .parity_err(a_pe), .frame_err(a_fe), .empty(a_empty),
        .full(a_full), .count(a_count), .overrun(a_ovr));

    uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(2)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_line[1]), .rd_en(rd_v[1]), .ovr_clr(clr_v[1]),
        .d_out(p_dout), .parity_err(p_pe), .frame_err(p_fe), .empty(p_empty),
        .full(p_full), .count(p_count), .overrun(p_ovr));

    uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .rx(rx_line[2]), .rd_en(rd_v[2]), .ovr_clr(clr_v[2]),
        .d_out(s_dout), .parity_err(s_pe), .frame_err(s_fe), .empty(s_empty),
        .full(s_full), .count(s_count), .overrun(s_ovr));

    uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .rst(rst), .rx(rx_line[3]), .rd_en(rd_v[3]), .ovr_clr(clr_v[3]),
        .d_out(o_dout), .parity_err(o_pe), .frame_err(o_fe), .empty(o_empty),
        .full(o_full), .count(o_count), .overrun(o_ovr));

    uart_rx_ext #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(5), .PARITY(1)) dut_w (
        .clk(clk), .rst(rst), .rx(rx_line[4]), .rd_en(rd_v[4]), .ovr_clr(clr_v[4]),
        .d_out(w_dout), .parity_err(w_pe), .frame_err(w_fe), .empty(w_empty),
        .full(w_full), .count(w_count), .overrun(w_ovr));

    // Drive one serial frame on line idx, LSB first, leaving the line idle high.
    // A low second stop bit is held for 3/4 of a bit so the receiver, which
    // rearms at mid-stop, sees only a short false start afterwards.
    task automatic send_frame(input int idx, input logic [8:0] data, input int dbits,
                              input int has_par, input logic par_bit,
                              input int nstop, input logic stop2);
        rx_line[idx] = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < dbits; i++) begin
            rx_line[idx] = data[i];
            #(BIT_NS);
        end
        if (has_par != 0) begin
            rx_line[idx] = par_bit;
            #(BIT_NS);
        end
        rx_line[idx] = 1'b1;
        #(BIT_NS);
        if (nstop == 2) begin
            if (stop2) begin
                #(BIT_NS);
            end else begin
                rx_line[idx] = 1'b0;
                #(BIT_NS * 3 / 4);
                rx_line[idx] = 1'b1;
                #(BIT_NS / 4);
            end
        end
    endtask

    // One-cycle read strobe; returns at the negedge after it was taken.
    task automatic pop(input int idx);
        @(negedge clk);
        rd_v[idx] = 1'b1;
        @(negedge clk);
        rd_v[idx] = 1'b0;
    endtask

    task automatic idle_bits(input int n);
        #(BIT_NS * n);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (a_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", a_full); end
        checks++; if (a_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", a_count); end
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", a_ovr); end
        checks++; if ({a_dout, a_pe, a_fe} !== 10'h000) begin errors++; $display("[TB] FAIL reset_head: got %h expected 000", {a_dout, a_pe, a_fe}); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_o_empty: got %b expected 1", o_empty); end
        rst = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_basic;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        checks++; if (a_empty !== 1'b0) begin errors++; $display("[TB] FAIL basic_empty: got %b expected 0", a_empty); end
        checks++; if (a_count !== 5'd1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", a_count); end
        checks++; if (a_dout !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", a_dout); end
        checks++; if ({a_pe, a_fe} !== 2'b00) begin errors++; $display("[TB] FAIL basic_flags: got %b expected 00", {a_pe, a_fe}); end
        pop(0);
        checks++; if (a_empty !== 1'b1) begin errors++; $display("[TB] FAIL basic_pop_empty: got %b expected 1", a_empty); end
        checks++; if (a_count !== 5'd0) begin errors++; $display("[TB] FAIL basic_pop_count: got %0d expected 0", a_count); end
        idle_bits(1);
    endtask

    task automatic test_back_to_back;
        send_frame(0, 9'h012, 8, 0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h034, 8, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        checks++; if (a_count !== 5'd2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", a_count); end
        checks++; if (a_dout !== 8'h12) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 12", a_dout); end
        pop(0);
        checks++; if (a_dout !== 8'h34) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 34", a_dout); end
        pop(0);
        checks++; if (a_empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 1", a_empty); end
        idle_bits(1);
    endtask

    task automatic test_parity;
        send_frame(1, 9'h03C, 8, 1, 1'b1, 1, 1'b1);
        @(negedge clk);
        checks++; if (p_dout !== 8'h3C) begin errors++; $display("[TB] FAIL par_bad_data: got %h expected 3c", p_dout); end
        checks++; if (p_pe !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_flag: got %b expected 1", p_pe); end
        pop(1);
        idle_bits(1);
        send_frame(1, 9'h03C, 8, 1, 1'b0, 1, 1'b1);
        @(negedge clk);
        checks++; if (p_dout !== 8'h3C) begin errors++; $display("[TB] FAIL par_good_data: got %h expected 3c", p_dout); end
        checks++; if ({p_pe, p_fe} !== 2'b00) begin errors++; $display("[TB] FAIL par_good_flags: got %b expected 00", {p_pe, p_fe}); end
        pop(1);
        checks++; if (p_empty !== 1'b1) begin errors++; $display("[TB] FAIL par_empty: got %b expected 1", p_empty); end
        idle_bits(1);
    endtask

    task automatic test_framing;
        send_frame(2, 9'h055, 8, 0, 1'b0, 2, 1'b0);
        @(negedge clk);
        checks++; if (s_dout !== 8'h55) begin errors++; $display("[TB] FAIL frm_bad_data: got %h expected 55", s_dout); end
        checks++; if (s_fe !== 1'b1) begin errors++; $display("[TB] FAIL frm_bad_flag: got %b expected 1", s_fe); end
        pop(2);
        idle_bits(2);
        send_frame(2, 9'h00F, 8, 0, 1'b0, 2, 1'b1);
        @(negedge clk);
        checks++; if (s_count !== 5'd1) begin errors++; $display("[TB] FAIL frm_next_count: got %0d expected 1", s_count); end
        checks++; if (s_dout !== 8'h0F) begin errors++; $display("[TB] FAIL frm_next_data: got %h expected 0f", s_dout); end
        checks++; if (s_fe !== 1'b0) begin errors++; $display("[TB] FAIL frm_next_flag: got %b expected 0", s_fe); end
        pop(2);
        idle_bits(1);
    endtask

    task automatic test_false_start;
        rx_line[0] = 1'b0;
        #(BIT_NS * 3 / 16);
        rx_line[0] = 1'b1;
        idle_bits(2);
        checks++; if (a_empty !== 1'b1) begin errors++; $display("[TB] FAIL fstart_empty: got %b expected 1", a_empty); end
        checks++; if (dut_a.state_q !== ST_IDLE) begin errors++; $display("[TB] FAIL fstart_state: got %0d expected %0d", dut_a.state_q, ST_IDLE); end
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        checks++; if (a_dout !== 8'h81) begin errors++; $display("[TB] FAIL fstart_next_data: got %h expected 81", a_dout); end
        checks++; if (a_count !== 5'd1) begin errors++; $display("[TB] FAIL fstart_next_count: got %0d expected 1", a_count); end
        pop(0);
        idle_bits(1);
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) begin
            send_frame(3, 9'(i), 8, 0, 1'b0, 1, 1'b1);
            idle_bits(1);
        end
        checks++; if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL ovr_full: got %b expected 1", o_full); end
        checks++; if (o_count !== 3'd4) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 4", o_count); end
        checks++; if (o_ovr !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected 1", o_ovr); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (o_dout !== 8'(i)) begin errors++; $display("[TB] FAIL ovr_read%0d: got %h expected %h", i, o_dout, 8'(i)); end
            pop(3);
        end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovr_drained: got %b expected 1", o_empty); end
        checks++; if (o_ovr !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %b expected 1", o_ovr); end
        @(negedge clk);
        clr_v[3] = 1'b1;
        @(negedge clk);
        clr_v[3] = 1'b0;
        checks++; if (o_ovr !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %b expected 0", o_ovr); end
    endtask

    task automatic test_width;
        send_frame(4, 9'h013, 5, 1, 1'b0, 1, 1'b1);
        @(negedge clk);
        checks++; if (w_dout !== 5'h13) begin errors++; $display("[TB] FAIL w5_data: got %h expected 13", w_dout); end
        checks++; if (w_pe !== 1'b0) begin errors++; $display("[TB] FAIL w5_par_ok: got %b expected 0", w_pe); end
        pop(4);
        idle_bits(1);
        send_frame(4, 9'h013, 5, 1, 1'b1, 1, 1'b1);
        @(negedge clk);
        checks++; if (w_pe !== 1'b1) begin errors++; $display("[TB] FAIL w5_par_bad: got %b expected 1", w_pe); end
        pop(4);
        idle_bits(1);
    endtask

    task automatic test_reset_midframe;
        fork
            send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1);
            begin
                #(BIT_NS * 4 + BIT_NS / 2);
                rst = 1'b1;
                #30;
                rst = 1'b0;
            end
        join
        idle_bits(1);
        checks++; if (a_empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_empty: got %b expected 1", a_empty); end
        checks++; if (a_count !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected 0", a_count); end
        checks++; if (dut_a.state_q !== ST_IDLE) begin errors++; $display("[TB] FAIL rstmid_state: got %0d expected %0d", dut_a.state_q, ST_IDLE); end
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
        @(negedge clk);
        checks++; if (a_dout !== 8'h5A) begin errors++; $display("[TB] FAIL rstmid_next_data: got %h expected 5a", a_dout); end
        checks++; if (a_count !== 5'd1) begin errors++; $display("[TB] FAIL rstmid_next_count: got %0d expected 1", a_count); end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            rx_line[i] = 1'b1;
            rd_v[i]    = 1'b0;
            clr_v[i]   = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset;
        test_basic;
        test_back_to_back;
        test_parity;
        test_framing;
        test_false_start;
        test_overrun;
        test_width;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds:
- configurable data width, parity and stop bits;
- an internal baud/oversample tick generator;
- a first-word-fall-through receive FIFO that stores per-word parity and framing error flags;
- a sticky overrun flag.

It sits between the pad-side `rx` line and the host read interface.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: clock frequency, Hz
- `BAUD`, 9600: line rate, bit/s
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8
- `DATA_BITS`, 8: payload bits per frame, 5..9
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1: 1 or 2
- `FIFO_DEPTH`, 16: entries; power of 2, ≥ 2

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `rx`  in  1  serial line, asynchronous, idle high
- `rd_en`  in  1  pop FIFO head; ignored when `empty`
- `ovr_clr`  in  1  clears `overrun`
- `d_out`  out  `DATA_BITS`  FIFO head data; valid while `!empty`
- `parity_err`  out  1  head entry parity error; forced 0 when `PARITY` = 0
- `frame_err`  out  1  head entry framing error
- `empty`  out  1  FIFO empty
- `full`  out  1  FIFO full
- `count`  out  `$clog2(FIFO_DEPTH+1)`  entries held
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full

## Operation
- **Input sync:** `rx` passes through a 2-FF synchroniser, reset value 1.
- **Tick generator:** counter `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)` (integer divide). It emits a 1-cycle `tick` when it reaches `DIV-1`, then wraps to 0. It free-runs and is not realigned per frame.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE: synchronised `rx` = 0 → START, tick count cleared.
  - START: after `OVERSAMPLE/2` ticks, sample the line.
    - 0 → DATA.
    - 1 → IDLE (false start; nothing pushed).
  - DATA: sample every `OVERSAMPLE` ticks, LSB first, into a shift register. After `DATA_BITS` samples → PAR if `PARITY` ≠ 0, else STOP.
  - PAR: one sample. `pe` = 1 when the XOR of data and the parity bit is not 1 (odd) or not 0 (even).
  - STOP: `STOP_BITS` samples at `OVERSAMPLE` spacing. Any sample = 0 sets `fe`.
  - After the last stop sample: push `{fe, pe, data}` → IDLE. The FSM returns at mid-stop-bit, so back-to-back frames are received.
- **FIFO:** first-word fall-through. Outputs show the head entry combinationally from storage.
  - Pop on `rd_en && !empty`.
  - Push when `full`, without a simultaneous pop: the frame is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both happen, `count` is unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- **Overrun flag:** `overrun` clears on `ovr_clr`. If a set and a clear occur in the same cycle, the set wins.
- **Reset:** asserting `rst` at any time, including mid-frame, aborts the frame.
  - FSM → IDLE, tick counter 0, FIFO pointers 0.
  - Outputs: `d_out` 0, `parity_err` 0, `frame_err` 0, `empty` 1, `full` 0, `count` 0, `overrun` 0.

## Timing
- Sync latency: 2 `clk` from an `rx` edge to the FSM.
- A start edge is detected within 1 `clk` of the synchronised falling edge.
- Bit samples occur `OVERSAMPLE/2 + k*OVERSAMPLE` ticks after start detection, k = 1…
- Push occurs on the cycle after the final stop-bit sample tick. `empty` falls and `count` increments on the following edge.
- `rd_en` sampled high at edge N: the next entry (or `empty` = 1) is visible after edge N.
- `full` and `empty` are registered and update in the same cycle as `count`.

## Structure
- Package `uart_pkg`:
  - FSM state enum;
  - `PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN` constants;
  - an entry-width function `DATA_BITS+2`.
- Sub-module `uart_sync_fifo` (params `WIDTH`, `DEPTH`): push, pop, full, empty, count, FWFT read.
- Tick generator and FSM stay in `uart_rx_ext`.

## Test plan
Defaults unless stated; 100 MHz clock, `BAUD` 9600, bit time 104166 ns.
- **Basic 8N1:** send 0xA5 → `empty` falls; `d_out` = 0xA5, `parity_err` = 0, `frame_err` = 0. Pulse `rd_en` → `empty` = 1, `count` = 0.
- **Parity error:** `PARITY` = 2, send 0x3C with parity bit 1 → `d_out` = 0x3C, `parity_err` = 1. Same byte with parity bit 0 → `parity_err` = 0.
- **Framing error:** `STOP_BITS` = 2, send 0x55 with the second stop bit 0 → `d_out` = 0x55, `frame_err` = 1. The next frame, 0x0F, is received clean.
- **False start:** drive `rx` low for 3/16 of a bit, then high → no push, `empty` stays 1. The following 0x81 is received correctly.
- **Overrun:** `FIFO_DEPTH` = 4, send 0x01..0x05 with no reads → `full` = 1, `count` = 4, `overrun` = 1. Reads return 01, 02, 03, 04. `ovr_clr` → `overrun` = 0.
- **Reset and width:** assert `rst` during data bit 3 of 0xFF → `empty` = 1, FSM IDLE; a following 0x5A is received correctly. Separately, with `DATA_BITS` = 5 and `PARITY` = 1, send 0x13 → `d_out` = 5'h13, `parity_err` = 0.
